// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver: PS/2 device-to-host frame receiver feeding a first-word-fall-through byte FIFO.
// Ports: clk, rst_n (async, active-low); ps2_clk/ps2_data raw pins; rd pops the head;
// code is the head byte (8'h00 while empty); empty/full FIFO flags; frame_err/overflow one-cycle pulses.
module ps2_scancode_receiver #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] code,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic c1, c2, c3, d1, d2, fall, timeout;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n, head_n;
  logic par_ok, par_ok_n, push, ferr_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr, rptr_n;
  logic [AW:0] cnt, cnt_n;
  logic wr, rdp;
  // c3 holds the previous synced clock so the edge is seen one cycle after c2 drops
  assign fall = c3 & ~c2;
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    par_ok_n = par_ok;
    push = 1'b0;
    ferr_n = 1'b0;
    tcnt_n = (fall || state == IDLE) ? '0 : tcnt + 1'b1;
    if (timeout) begin
      state_n = IDLE;
      ferr_n = 1'b1;
      tcnt_n = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          state_n = d2 ? IDLE : DATA;
          bit_cnt_n = d2 ? bit_cnt : 3'd0;
        end
        DATA: begin
          sh_n = {d2, sh[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_n = ^{sh, d2};
          state_n = STOP;
        end
        STOP: begin
          push = d2 & par_ok;
          ferr_n = ~(d2 & par_ok);
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // A push into a full FIFO still lands when the same cycle pops the head
  assign wr = push && (!full || rd);
  assign rdp = rd && !empty;
  assign rptr_n = rptr + AW'(rdp);
  assign cnt_n = cnt + (AW+1)'(wr) - (AW+1)'(rdp);
  // Forward the byte being written when it becomes the new head
  assign head_n = (cnt_n == '0) ? 8'h00 : (wr && rptr_n == wptr) ? sh : mem[rptr_n];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {c1, c2, c3, d1, d2} <= 5'b11111;
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      par_ok <= 1'b0;
      tcnt <= '0;
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
      code <= 8'h00;
      empty <= 1'b1;
      full <= 1'b0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      {c1, c2, c3} <= {ps2_clk, c1, c2};
      {d1, d2} <= {ps2_data, d1};
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      par_ok <= par_ok_n;
      tcnt <= tcnt_n;
      rptr <= rptr_n;
      wptr <= wptr + AW'(wr);
      cnt <= cnt_n;
      code <= head_n;
      empty <= cnt_n == '0;
      full <= cnt_n == (AW+1)'(FIFO_DEPTH);
      frame_err <= ferr_n;
      overflow <= push && full && !rd;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wptr] <= sh;
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver: directed self-checking bench for ps2_scancode_receiver.
`timescale 1ns/1ps
module tb_ps2_scancode_receiver;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rd = 1'b0;
  logic [7:0] code;
  logic empty, full, frame_err, overflow;
  int n_assert = 0, n_fail = 0, ferr_cnt = 0, ovf_cnt = 0, f0, o0;
  ps2_scancode_receiver dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
    .code(code), .empty(empty), .full(full), .frame_err(frame_err), .overflow(overflow)
  );
  always #500 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // 80 us PS/2 bit period (12.5 kHz); all pin changes land on clk falling edges
  task automatic send_bits(input logic [10:0] f, input int n, input logic rd_on_last);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #20000 ps2_clk = 1'b0;
      if (i == n - 1 && rd_on_last) begin
        #2000 rd = 1'b1;
        #1000 rd = 1'b0;
        #37000;
      end else #40000;
      ps2_clk = 1'b1;
      #20000;
    end
    ps2_data = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop_bit, input logic rd_on_stop);
    send_bits({stop_bit, par_good ? ~^b : ^b, b, 1'b0}, 11, rd_on_stop);
  endtask
  task automatic pop();
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", 32'(code), 32'h00);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("good_code", 32'(code), 32'h1C);
    chk("good_empty", 32'(empty), 0);
    chk("good_ferr", 32'(ferr_cnt - f0), 0);
    pop();
    chk("pop_empty", 32'(empty), 1);
    chk("pop_code", 32'(code), 32'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("badpar_ferr", 32'(ferr_cnt - f0), 1);
    chk("badpar_empty", 32'(empty), 1);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk("badstop_ferr", 32'(ferr_cnt - f0), 2);
    chk("badstop_empty", 32'(empty), 1);
    o0 = ovf_cnt;
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, 1'b0);
      if (i == 7) chk("full_at7", 32'(full), 0);
    end
    chk("full_at8", 32'(full), 1);
    chk("head_at8", 32'(code), 32'h01);
    send_frame(8'h09, 1'b1, 1'b1, 1'b0);
    chk("ovf_pulse", 32'(ovf_cnt - o0), 1);
    chk("ovf_full", 32'(full), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain1", 32'(code), 32'(i));
      pop();
    end
    chk("drain1_empty", 32'(empty), 1);
    chk("drain1_code", 32'(code), 32'h00);
    o0 = ovf_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    send_frame(8'h09, 1'b1, 1'b1, 1'b1);
    chk("simrd_ovf", 32'(ovf_cnt - o0), 0);
    chk("simrd_full", 32'(full), 1);
    for (int i = 2; i <= 9; i++) begin
      chk("drain2", 32'(code), 32'(i));
      pop();
    end
    chk("drain2_empty", 32'(empty), 1);
    chk("drain2_notfull", 32'(full), 0);
    f0 = ferr_cnt;
    send_bits(11'b000_0000_1010, 4, 1'b0);
    #6000000;
    chk("tmo_ferr", 32'(ferr_cnt - f0), 1);
    chk("tmo_empty", 32'(empty), 1);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    chk("tmo_next_code", 32'(code), 32'hF0);
    chk("tmo_next_ferr", 32'(ferr_cnt - f0), 1);
    pop();
    f0 = ferr_cnt;
    ps2_data = 1'b1;
    #20000 ps2_clk = 1'b0;
    #40000 ps2_clk = 1'b1;
    #20000;
    chk("glitch_ferr", 32'(ferr_cnt - f0), 0);
    chk("glitch_empty", 32'(empty), 1);
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    chk("q3_code", 32'(code), 32'h11);
    send_bits(11'b000_0000_0110, 3, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_code", 32'(code), 32'h00);
    chk("midrst_full", 32'(full), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("after_rst_code", 32'(code), 32'h5A);
    chk("after_rst_ferr", 32'(ferr_cnt - f0), 0);
    pop();
    chk("after_rst_pop", 32'(empty), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
